// File: rtl/lane_scheduler.sv
// Turns the speed setting into periodic sweeps that strobe lanes 1..NLANES once each, one lane per clock.
// Sweep starts the clock after the triggering base tick and takes NLANES+1 cycles; no backpressure, a started sweep always completes.
module lane_scheduler #(
  parameter int                PRESCALE  = 50000,
  parameter int                NLANES    = 14,
  parameter logic [NLANES-1:0] FAST_MASK = 14'h1555
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        speed,
  input  logic              pause,
  input  logic [NLANES-1:0] lane_mask,
  output logic [NLANES-1:0] shift,
  output logic              busy,
  output logic              sweep_done,
  output logic              sweep_parity,
  output logic [15:0]       sweep_count
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NLANES + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     pre_cnt;
  logic [8:0]        period_cnt;
  logic [IW-1:0]     idx;
  logic              base_tick;
  logic [8:0]        thr;
  logic [8:0]        period_inc;
  logic [NLANES-1:0] lane_en;

  assign base_tick  = (pre_cnt == PW'(PRESCALE - 1));
  assign thr        = 9'd256 - {1'b0, speed};
  assign period_inc = period_cnt + 9'd1;
  // Slow lanes only move on even sweeps.
  assign lane_en    = lane_mask & (FAST_MASK | {NLANES{~sweep_parity}});

  function automatic logic [NLANES-1:0] lane_onehot(input logic [IW-1:0] lane);
    lane_onehot = NLANES'(1) << (lane - IW'(1));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (base_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // shift is registered: each strobe is computed on the edge that enters its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period_cnt   <= '0;
      idx          <= IW'(1);
      shift        <= '0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      sweep_parity <= 1'b0;
      sweep_count  <= '0;
    end else begin
      shift      <= '0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (base_tick && !pause) begin
            if (period_inc >= thr) begin
              period_cnt <= '0;
              idx        <= IW'(1);
              busy       <= 1'b1;
              shift      <= lane_onehot(IW'(1)) & lane_en;
              state      <= SWEEP;
            end else begin
              period_cnt <= period_inc;
            end
          end
        end
        SWEEP: begin
          if (idx == IW'(NLANES)) begin
            sweep_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx   <= idx + IW'(1);
            shift <= lane_onehot(idx + IW'(1)) & lane_en;
          end
        end
        DONE: begin
          busy         <= 1'b0;
          idx          <= IW'(1);
          sweep_parity <= ~sweep_parity;
          sweep_count  <= sweep_count + 16'd1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Bench for lane_scheduler: scoreboard of expected strobe patterns, per-scenario tasks.
module tb_lane_scheduler;

  localparam int                PRESCALE  = 4;
  localparam int                NLANES    = 14;
  localparam logic [NLANES-1:0] FAST_MASK = 14'h1555;

  typedef logic [NLANES-1:0] lane_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  speed;
  logic        pause;
  lane_t       lane_mask;
  lane_t       shift;
  logic        busy;
  logic        sweep_done;
  logic        sweep_parity;
  logic [15:0] sweep_count;

  lane_scheduler #(
    .PRESCALE (PRESCALE),
    .NLANES   (NLANES),
    .FAST_MASK(FAST_MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .speed       (speed),
    .pause       (pause),
    .lane_mask   (lane_mask),
    .shift       (shift),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_parity(sweep_parity),
    .sweep_count (sweep_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_start = 0;
  logic [15:0] m_count = 16'd0;
  logic        m_parity = 1'b0;
  lane_t       exp_q[$];

  // Cycles between consecutive sweep starts. With PRESCALE=4 and NLANES+1=15 the first
  // IDLE cycle after a sweep always lands on a base tick, so the phase term is fixed.
  function automatic int gap(input int thr);
    return (NLANES + 1) + (thr - 1) * PRESCALE + 1;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic push_sweep(input lane_t mask);
    lane_t fm;
    lane_t one;
    fm  = FAST_MASK;
    one = lane_t'(1);
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i] && (fm[i] || !m_parity)) exp_q.push_back(one << i);
      else exp_q.push_back('0);
    end
  endtask

  task automatic wait_busy(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: busy never rose, got 0 required 1", name);
    end
  endtask

  // Follows one full sweep from its first cycle to the first IDLE cycle after it.
  task automatic check_sweep(input string name, input int exp_start);
    bit    ok;
    lane_t exp;
    wait_busy(name, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    checks++;
    if (cyc !== exp_start) begin
      errors++;
      $display("FAIL %s start: cycle %0d required %0d", name, cyc, exp_start);
    end
    last_start = cyc;
    for (int i = 0; i < NLANES; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({busy, sweep_done, shift} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL %s lane %0d: busy=%b done=%b shift=%h required busy=1 done=0 shift=%h",
                 name, i + 1, busy, sweep_done, shift, exp);
      end
      tick();
    end
    checks++;
    if ({busy, sweep_done, shift} !== {1'b1, 1'b1, lane_t'(0)}) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b shift=%h required 1 1 0",
               name, busy, sweep_done, shift);
    end
    tick();
    m_count  = m_count + 16'd1;
    m_parity = ~m_parity;
    checks++;
    if ({busy, sweep_done, sweep_parity, sweep_count} !== {1'b0, 1'b0, m_parity, m_count}) begin
      errors++;
      $display("FAIL %s after: busy=%b done=%b parity=%b count=%h required 0 0 %b %h",
               name, busy, sweep_done, sweep_parity, sweep_count, m_parity, m_count);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    speed     = 8'd254;
    pause     = 1'b0;
    lane_mask = '1;
    step(3);
    reset = 1'b0;
    step(12);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({shift, busy, sweep_done, sweep_parity, sweep_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: shift=%h busy=%b done=%b parity=%b count=%h required all 0",
               shift, busy, sweep_done, sweep_parity, sweep_count);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc   = 1;
    checks++;
    if ({shift, busy, sweep_done, sweep_parity, sweep_count} !== '0) begin
      errors++;
      $display("FAIL release_outputs: shift=%h busy=%b done=%b parity=%b count=%h required all 0",
               shift, busy, sweep_done, sweep_parity, sweep_count);
    end
    m_count  = 16'd0;
    m_parity = 1'b0;
  endtask

  task automatic test_first_sweep();
    push_sweep('1);
    check_sweep("first_sweep", 9);
  endtask

  task automatic test_second_sweep();
    push_sweep('1);
    check_sweep("second_sweep", last_start + gap(2));
  endtask

  task automatic test_period();
    speed = 8'd0;
    push_sweep('1);
    check_sweep("period_256", last_start + gap(256));
    step(100);
    pause = 1'b1;
    step(40);
    pause = 1'b0;
    push_sweep('1);
    check_sweep("period_paused", last_start + gap(256) + 40);
  endtask

  task automatic test_mask_off();
    speed     = 8'd254;
    lane_mask = '0;
    push_sweep('0);
    check_sweep("mask_off", last_start + gap(2));
    lane_mask = '1;
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit saw;
    wait_busy("abort_wait", ok);
    if (!ok) return;
    step(6);
    checks++;
    if (shift !== lane_t'(14'h0040)) begin
      errors++;
      $display("FAIL abort_idx7: shift=%h required 0040", shift);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({shift, busy, sweep_done, sweep_count} !== '0) begin
      errors++;
      $display("FAIL abort_reset: shift=%h busy=%b done=%b count=%h required all 0",
               shift, busy, sweep_done, sweep_count);
    end
    @(negedge clk);
    reset    = 1'b0;
    cyc      = 1;
    m_count  = 16'd0;
    m_parity = 1'b0;
    saw      = 1'b0;
    for (int n = 0; n < 7; n++) begin
      tick();
      if (sweep_done !== 1'b0 || busy !== 1'b0 || sweep_count !== 16'd0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: activity seen=%b required 0", saw);
    end
    force dut.sweep_count = 16'hFFFF;
    #1 release dut.sweep_count;
    m_count = 16'hFFFF;
    push_sweep('1);
    check_sweep("count_wrap", 9);
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_second_sweep();
    test_period();
    test_mask_off();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
